// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch stage with prefetch queue and IF/ID register
//
// Purpose: owns the fetch PC, issues one-at-a-time requests to a variable
// latency instruction memory, buffers returned instructions in a FQ_DEPTH
// entry queue and drives the IF/ID pipeline register.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc_select_e       execute-stage redirect, target on pc_branch_e
//   stall_d, flush_d  decode hold / bubble insertion
//   imem_req/addr     request valid and address (address is the fetch PC)
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid/rdata response valid and instruction
//   instr_d, pc_d, pc_next_d, valid_d   IF/ID register outputs

module fetch_queue_unit #(
  parameter int unsigned        XLEN      = 16,
  parameter int unsigned        INSTR_W   = 16,
  parameter int unsigned        FQ_DEPTH  = 4,
  parameter logic [XLEN-1:0]    RESET_PC  = '0,
  parameter logic [XLEN-1:0]    PC_STEP   = XLEN'(1),
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_select_e,
  input  logic [XLEN-1:0]    pc_branch_e,
  input  logic               stall_d,
  input  logic               flush_d,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_d,
  output logic [XLEN-1:0]    pc_d,
  output logic [XLEN-1:0]    pc_next_d,
  output logic               valid_d
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  // Space thresholds: with nothing in flight one free slot is enough; when a
  // response lands this cycle it consumes a slot, so two must be free.
  localparam logic [CNT_W-1:0] SPACE_IDLE = CNT_W'(FQ_DEPTH - 1);
  localparam logic [CNT_W-1:0] SPACE_BUSY = CNT_W'(FQ_DEPTH - 2);

  logic [XLEN-1:0]    pc_f_q, pc_f_d;
  logic               outstanding_q, outstanding_d;
  logic [XLEN-1:0]    req_pc_q, req_pc_d;
  logic               kill_q, kill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0]    q_pc_q    [FQ_DEPTH];
  logic [INSTR_W-1:0] q_instr_q [FQ_DEPTH];

  logic [INSTR_W-1:0] instr_q, instr_n;
  logic [XLEN-1:0]    pc_out_q, pc_out_n;
  logic [XLEN-1:0]    pc_next_q, pc_next_n;
  logic               valid_q, valid_n;

  logic space_ok;
  logic accept;
  logic resp;
  logic push;
  logic pop;

  // Issue decision uses only registered state plus rvalid/redirect inputs;
  // a same-cycle pop is deliberately not credited.
  assign space_ok = (!outstanding_q && (count_q <= SPACE_IDLE)) ||
                    (outstanding_q && imem_rvalid && (count_q <= SPACE_BUSY));
  assign imem_req  = !rst && !pc_select_e && !kill_q && space_ok;
  assign imem_addr = pc_f_q;
  assign accept    = imem_req && imem_ready;

  // rvalid without a request in flight (e.g. left over from before reset) is ignored.
  assign resp = outstanding_q && imem_rvalid;
  assign push = resp && !kill_q && !pc_select_e;

  // IF/ID register next state and queue pop.
  always_comb begin
    pop       = 1'b0;
    instr_n   = instr_q;
    pc_out_n  = pc_out_q;
    pc_next_n = pc_next_q;
    valid_n   = valid_q;
    if (pc_select_e || flush_d) begin
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
    end else if (stall_d) begin
      // hold everything
    end else if (count_q != '0) begin
      pop       = 1'b1;
      instr_n   = q_instr_q[rd_ptr_q];
      pc_out_n  = q_pc_q[rd_ptr_q];
      pc_next_n = q_pc_q[rd_ptr_q] + PC_STEP;
      valid_n   = 1'b1;
    end else begin
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
    end
  end

  // Fetch-side and queue bookkeeping next state.
  always_comb begin
    pc_f_d        = pc_f_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (accept) begin
      req_pc_d      = pc_f_q;
      pc_f_d        = pc_f_q + PC_STEP;
      outstanding_d = 1'b1;
    end else if (resp) begin
      outstanding_d = 1'b0;
    end

    // Any returning response retires a pending kill, whether or not it was kept.
    if (resp) begin
      kill_d = 1'b0;
    end

    if (pc_select_e) begin
      pc_f_d   = pc_branch_e;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      // Response still to come belongs to the wrong path.
      if (outstanding_q && !imem_rvalid) begin
        kill_d = 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q        <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      instr_q       <= NOP_INSTR;
      pc_out_q      <= '0;
      pc_next_q     <= '0;
      valid_q       <= 1'b0;
    end else begin
      pc_f_q        <= pc_f_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      instr_q       <= instr_n;
      pc_out_q      <= pc_out_n;
      pc_next_q     <= pc_next_n;
      valid_q       <= valid_n;
    end
  end

  // Queue payload needs no reset; count and pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_q[wr_ptr_q]    <= req_pc_q;
      q_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign instr_d   = instr_q;
  assign pc_d      = pc_out_q;
  assign pc_next_d = pc_next_q;
  assign valid_d   = valid_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit

module tb_fetch_queue_unit;

  localparam logic [15:0] XOR_K = 16'hA500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        pc_select_e = 1'b0;
  logic [15:0] pc_branch_e = '0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr_d, pc_d, pc_next_d;
  logic        valid_d;

  logic        b_req;
  logic [15:0] b_addr;
  logic        b_ready = 1'b1;
  logic        b_rvalid = 1'b0;
  logic [15:0] b_rdata = '0;
  logic [15:0] b_instr, b_pc, b_pcn;
  logic        b_valid;

  logic        b_sel = 1'b0;
  logic [15:0] b_tgt = '0;
  logic        b_stall = 1'b0;
  logic        b_flush = 1'b0;

  fetch_queue_unit dut (
    .clk(clk), .rst(rst), .pc_select_e(pc_select_e), .pc_branch_e(pc_branch_e),
    .stall_d(stall_d), .flush_d(flush_d), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_next_d(pc_next_d), .valid_d(valid_d)
  );

  fetch_queue_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .pc_select_e(b_sel), .pc_branch_e(b_tgt),
    .stall_d(b_stall), .flush_d(b_flush), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(b_ready), .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .instr_d(b_instr), .pc_d(b_pc), .pc_next_d(b_pcn), .valid_d(b_valid)
  );

  // Variable-latency memory model: response lat cycles after accept, data = addr ^ A500.
  int          lat = 1;
  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic [15:0] m_addr = '0;
  always @(posedge clk) begin
    if (imem_rvalid) m_busy = 1'b0;
    if (imem_req && imem_ready) begin
      m_busy = 1'b1;
      m_addr = imem_addr;
      m_wait = lat - 1;
    end else if (m_busy && m_wait > 0) begin
      m_wait = m_wait - 1;
    end
    if (m_busy && m_wait == 0) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= m_addr ^ XOR_K;
    end else begin
      imem_rvalid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    b_rvalid <= b_req && b_ready;
    b_rdata  <= b_addr ^ XOR_K;
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] bexp_q[$];
  logic [15:0] nxt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    total_cnt++;
    if ({valid_d, instr_d, pc_d, pc_next_d} !== {1'b0, 16'h0, 16'h0, 16'h0})
      $display("FAIL reset_outputs got v=%b i=%h pc=%h pcn=%h want 0 0000 0000 0000", valid_d, instr_d, pc_d, pc_next_d);
    else pass_cnt++;
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b0, 16'h0000})
      $display("FAIL reset_imem got req=%b addr=%h want 0 0000", imem_req, imem_addr);
    else pass_cnt++;
    total_cnt++;
    if ({b_req, b_addr, b_valid} !== {1'b0, 16'hFFFE, 1'b0})
      $display("FAIL reset_wrap_pc got req=%b addr=%h v=%b want 0 fffe 0", b_req, b_addr, b_valid);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [15:0] e;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000})
      $display("FAIL stream_first_req got req=%b addr=%h want 1 0000", imem_req, imem_addr);
    else pass_cnt++;
    for (int c = 1; c < 3; c++) begin
      step();
      total_cnt++;
      if (valid_d !== 1'b0) $display("FAIL stream_early_valid cycle %0d got %b want 0", c, valid_d);
      else pass_cnt++;
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(16'(k));
    bexp_q.push_back(16'hFFFE); bexp_q.push_back(16'hFFFF); bexp_q.push_back(16'h0000);
    for (int c = 3; c < 11; c++) begin
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if ({valid_d, instr_d, pc_d, pc_next_d} !== {1'b1, e ^ XOR_K, e, e + 16'd1})
        $display("FAIL stream_seq cycle %0d got v=%b i=%h pc=%h pcn=%h want pc=%h", c, valid_d, instr_d, pc_d, pc_next_d, e);
      else pass_cnt++;
      if (bexp_q.size() > 0) begin
        e = bexp_q.pop_front();
        total_cnt++;
        if ({b_valid, b_instr, b_pc, b_pcn} !== {1'b1, e ^ XOR_K, e, e + 16'd1})
          $display("FAIL wrap_seq cycle %0d got v=%b i=%h pc=%h pcn=%h want pc=%h", c, b_valid, b_instr, b_pc, b_pcn, e);
        else pass_cnt++;
      end
    end
    nxt = 16'd8;
  endtask

  task automatic test_stall();
    logic [15:0] h;
    logic [15:0] e;
    int budget;
    h = nxt - 16'd1;
    stall_d = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      total_cnt++;
      if ({valid_d, instr_d, pc_d, pc_next_d} !== {1'b1, h ^ XOR_K, h, nxt})
        $display("FAIL stall_hold k=%0d got v=%b i=%h pc=%h pcn=%h want pc=%h", k, valid_d, instr_d, pc_d, pc_next_d, h);
      else pass_cnt++;
      if (k == 4) begin
        total_cnt++;
        if ({dut.count_q, imem_req} !== {3'd4, 1'b0})
          $display("FAIL stall_full got count=%0d req=%b want 4 0", dut.count_q, imem_req);
        else pass_cnt++;
      end
    end
    stall_d = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(nxt + 16'(k));
    budget = 0;
    while (exp_q.size() > 0 && budget < 40) begin
      step(); budget++;
      if (valid_d === 1'b1) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({instr_d, pc_d, pc_next_d} !== {e ^ XOR_K, e, e + 16'd1})
          $display("FAIL stall_order got i=%h pc=%h pcn=%h want pc=%h", instr_d, pc_d, pc_next_d, e);
        else pass_cnt++;
      end
    end
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL stall_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    nxt = nxt + 16'd8;
  endtask

  task automatic test_redirect();
    logic [15:0] e;
    pc_select_e = 1'b1;
    pc_branch_e = 16'h00A7;
    step();
    pc_select_e = 1'b0;
    #1;
    total_cnt++;
    if ({valid_d, instr_d} !== {1'b0, 16'h0000})
      $display("FAIL redir_bubble got v=%b i=%h want 0 0000", valid_d, instr_d);
    else pass_cnt++;
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h00A7})
      $display("FAIL redir_req got req=%b addr=%h want 1 00a7", imem_req, imem_addr);
    else pass_cnt++;
    for (int k = 2; k < 4; k++) begin
      step();
      total_cnt++;
      if (valid_d !== 1'b0) $display("FAIL redir_stale n+%0d got v=%b pc=%h want v=0", k, valid_d, pc_d);
      else pass_cnt++;
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(16'h00A7 + 16'(k));
    for (int k = 0; k < 8; k++) begin
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if ({valid_d, instr_d, pc_d, pc_next_d} !== {1'b1, e ^ XOR_K, e, e + 16'd1})
        $display("FAIL redir_seq n+%0d got v=%b i=%h pc=%h pcn=%h want pc=%h", k + 4, valid_d, instr_d, pc_d, pc_next_d, e);
      else pass_cnt++;
    end
    nxt = 16'h00AF;
  endtask

  task automatic test_kill();
    logic [15:0] e;
    int budget;
    lat = 3;
    for (int k = 0; k < 10; k++) step();
    budget = 0;
    while (imem_rvalid !== 1'b1 && budget < 10) begin
      step(); budget++;
    end
    total_cnt++;
    if ({imem_rvalid, imem_req} !== 2'b11)
      $display("FAIL kill_setup got rvalid=%b req=%b want 1 1", imem_rvalid, imem_req);
    else pass_cnt++;
    step();
    pc_select_e = 1'b1;
    pc_branch_e = 16'h0040;
    for (int k = 1; k < 3; k++) begin
      step();
      pc_select_e = 1'b0;
      #1;
      total_cnt++;
      if (imem_req !== 1'b0) $display("FAIL kill_noreq r+%0d got req=%b addr=%h want 0", k, imem_req, imem_addr);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0040})
      $display("FAIL kill_target_req got req=%b addr=%h want 1 0040", imem_req, imem_addr);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) exp_q.push_back(16'h0040 + 16'(k));
    budget = 0;
    while (exp_q.size() > 0 && budget < 40) begin
      step(); budget++;
      if (valid_d === 1'b1) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({instr_d, pc_d, pc_next_d} !== {e ^ XOR_K, e, e + 16'd1})
          $display("FAIL kill_order got i=%h pc=%h pcn=%h want pc=%h", instr_d, pc_d, pc_next_d, e);
        else pass_cnt++;
      end
    end
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL kill_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    lat = 1;
    nxt = 16'h0043;
  endtask

  task automatic test_flush_stall();
    logic [15:0] e;
    int budget;
    flush_d = 1'b1;
    stall_d = 1'b1;
    step();
    flush_d = 1'b0;
    stall_d = 1'b0;
    total_cnt++;
    if ({valid_d, instr_d} !== {1'b0, 16'h0000})
      $display("FAIL flush_stall_bubble got v=%b i=%h want 0 0000", valid_d, instr_d);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) exp_q.push_back(nxt + 16'(k));
    budget = 0;
    while (exp_q.size() > 0 && budget < 40) begin
      step(); budget++;
      if (valid_d === 1'b1) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({instr_d, pc_d, pc_next_d} !== {e ^ XOR_K, e, e + 16'd1})
          $display("FAIL flush_order got i=%h pc=%h pcn=%h want pc=%h", instr_d, pc_d, pc_next_d, e);
        else pass_cnt++;
      end
    end
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL flush_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    int budget;
    lat = 2;
    for (int k = 0; k < 6; k++) step();
    budget = 0;
    while (!(imem_req === 1'b1 && imem_ready === 1'b1) && budget < 10) begin
      step(); budget++;
    end
    step();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (imem_req !== 1'b0) $display("FAIL rst_mid_req got %b want 0", imem_req);
    else pass_cnt++;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({valid_d, instr_d, pc_d, pc_next_d, imem_addr} !== {1'b0, 16'h0, 16'h0, 16'h0, 16'h0})
      $display("FAIL rst_mid_outputs got v=%b i=%h pc=%h pcn=%h addr=%h want all 0", valid_d, instr_d, pc_d, pc_next_d, imem_addr);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) exp_q.push_back(16'(k));
    budget = 0;
    while (exp_q.size() > 0 && budget < 40) begin
      step(); budget++;
      if (valid_d === 1'b1) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({instr_d, pc_d, pc_next_d} !== {e ^ XOR_K, e, e + 16'd1})
          $display("FAIL rst_mid_order got i=%h pc=%h pcn=%h want pc=%h", instr_d, pc_d, pc_next_d, e);
        else pass_cnt++;
      end
    end
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL rst_mid_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_kill();
    test_flush_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
